step_seq11: RTL and testbench

- Modulo-11 step sequencer that generates the 4-bit binary code consumed by the 4-to-11 one-hot decode stage downstream. Its count output connects directly to that stage's B input.
- Steps through 0..MAX_VAL at a prescaled rate. Supports up/down direction, synchronous load and clear, run/stop control and a terminal-count pulse.
- Sits between the front-panel control logic and the decoder/lamp-driver chain.

---
 rtl/step_seq_pkg.sv | 14 +
 rtl/step_seq11_if.sv | 26 ++
 rtl/step_prescaler.sv | 37 +++
 rtl/step_seq11.sv | 107 ++++++++++
 tb/tb_step_seq11.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/step_seq_pkg.sv
// Shared types and sizing for the modulo-11 step sequencer.
package step_seq_pkg;

  localparam int unsigned CNT_W        = 4;
  localparam int unsigned DEF_MAX_VAL  = 10;
  localparam int unsigned DEF_PRESCALE = 4;
  localparam int unsigned DEF_PW       = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/step_seq11_if.sv
// Control/status bundle between the front-panel logic and the step sequencer.
interface step_seq11_if;
  import step_seq_pkg::*;

  logic             start;
  logic             stop;
  logic             dir;
  logic             clear;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  logic             running;
  logic             tc;
  logic             load_err;

  modport master (
    output start, stop, dir, clear, load, load_val,
    input  count, running, tc, load_err
  );

  modport slave (
    input  start, stop, dir, clear, load, load_val,
    output count, running, tc, load_err
  );

endinterface

// File: rtl/step_prescaler.sv
// PW-bit rate divider: asserts step_tick_c on the enabled cycle where it wraps.
module step_prescaler
  import step_seq_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned PW       = DEF_PW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step_tick_c
);

  localparam logic [PW-1:0] TERM = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d       = cnt_q;
    step_tick_c = en && (cnt_q == TERM);
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/step_seq11.sv
// Modulo-(MAX_VAL+1) up/down step sequencer feeding the one-hot decode stage.
module step_seq11
  import step_seq_pkg::*;
#(
  parameter int unsigned MAX_VAL  = DEF_MAX_VAL,
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned PW       = DEF_PW
) (
  input  logic        clk,
  input  logic        rst_n,
  step_seq11_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             running_q, running_d;
  logic             tc_q, tc_d;
  logic             load_err_q, load_err_d;
  logic             pre_clr_c, pre_en_c, step_tick_c;

  step_prescaler #(
    .PRESCALE (PRESCALE),
    .PW       (PW)
  ) u_prescaler (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (pre_clr_c),
    .en          (pre_en_c),
    .step_tick_c (step_tick_c)
  );

  // Next state plus clear > load > step priority on the count register.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    pre_clr_c  = 1'b0;
    pre_en_c   = (state_q == ST_RUN);

    case (state_q)
      ST_IDLE: begin
        pre_clr_c = 1'b1;
        if (bus.start && !bus.stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.clear) begin
      count_d   = '0;
      pre_clr_c = 1'b1;
    end else if (bus.load) begin
      pre_clr_c = 1'b1;
      if (bus.load_val > MAX_C) begin
        count_d    = MAX_C;
        load_err_d = 1'b1;
      end else begin
        count_d = bus.load_val;
      end
    end else if (step_tick_c && !bus.stop) begin
      if (bus.dir) begin
        if (count_q >= MAX_C) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX_C;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      running_q  <= 1'b0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      running_q  <= running_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.running  = running_q;
  assign bus.tc       = tc_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_step_seq11.sv
// Scoreboard bench for step_seq11: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_step_seq11;
  import step_seq_pkg::*;

  typedef struct packed {
    logic             start;
    logic             stop;
    logic             dir;
    logic             clear;
    logic             load;
    logic [CNT_W-1:0] load_val;
  } stim_t;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic             running;
    logic             tc;
    logic             load_err;
  } exp_t;

  logic  clk;
  logic  rst_n;
  int    checks;
  int    failures;
  string cur_test;
  exp_t  q[$];

  step_seq11_if b1 ();
  step_seq11_if b4 ();

  step_seq11 #(.MAX_VAL(10), .PRESCALE(1), .PW(8)) u_p1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  step_seq11 #(.MAX_VAL(10), .PRESCALE(4), .PW(8)) u_p4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic stim_t mk_s(bit st, bit sp, bit d, bit cl, bit ld, int v);
    stim_t s;
    s.start    = st;
    s.stop     = sp;
    s.dir      = d;
    s.clear    = cl;
    s.load     = ld;
    s.load_val = CNT_W'(v);
    return s;
  endfunction

  function automatic exp_t mk_e(int c, bit run, bit t, bit err);
    exp_t e;
    e.count    = CNT_W'(c);
    e.running  = run;
    e.tc       = t;
    e.load_err = err;
    return e;
  endfunction

  function automatic exp_t obs1();
    exp_t o;
    o.count = b1.count; o.running = b1.running; o.tc = b1.tc; o.load_err = b1.load_err;
    return o;
  endfunction

  function automatic exp_t obs4();
    exp_t o;
    o.count = b4.count; o.running = b4.running; o.tc = b4.tc; o.load_err = b4.load_err;
    return o;
  endfunction

  task automatic drive1(input stim_t s);
    b1.start = s.start; b1.stop = s.stop; b1.dir = s.dir;
    b1.clear = s.clear; b1.load = s.load; b1.load_val = s.load_val;
  endtask

  task automatic drive4(input stim_t s);
    b4.start = s.start; b4.stop = s.stop; b4.dir = s.dir;
    b4.clear = s.clear; b4.load = s.load; b4.load_val = s.load_val;
  endtask

  task automatic test_reset();
    exp_t o, e;
    cur_test = "reset";
    rst_n = 1'b0;
    drive1('0);
    drive4('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    o = obs1();
    checks++;
    if (o !== exp_t'('0)) begin
      failures++;
      $display("FAIL reset_p1 got=%h exp=%h", o, exp_t'('0));
    end
    o = obs4();
    checks++;
    if (o !== exp_t'('0)) begin
      failures++;
      $display("FAIL reset_p4 got=%h exp=%h", o, exp_t'('0));
    end
    rst_n = 1'b1;
    for (int r = 0; r < 20; r++) begin
      q.push_back(mk_e(0, 0, 0, 0));
      @(posedge clk);
      @(negedge clk);
      o = obs4();
      e = q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s row=%0d got cnt=%0d run=%0b tc=%0b err=%0b exp cnt=%0d run=%0b tc=%0b err=%0b",
                 cur_test, r, o.count, o.running, o.tc, o.load_err, e.count, e.running, e.tc, e.load_err);
      end
    end
  endtask

  task automatic test_up_wrap();
    stim_t s;
    exp_t  o, e;
    cur_test = "up_wrap";
    for (int k = 0; k <= 13; k++) begin
      s = mk_s(k == 0, k == 13, 1, 0, 0, 0);
      drive1(s);
      if (k == 13) q.push_back(mk_e(1, 0, 0, 0));
      else         q.push_back(mk_e(k % 11, 1, k == 11, 0));
      @(posedge clk);
      @(negedge clk);
      o = obs1();
      e = q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s row=%0d got cnt=%0d run=%0b tc=%0b err=%0b exp cnt=%0d run=%0b tc=%0b err=%0b",
                 cur_test, k, o.count, o.running, o.tc, o.load_err, e.count, e.running, e.tc, e.load_err);
      end
    end
    drive1('0);
  endtask

  task automatic test_down_wrap();
    stim_t sq[$];
    stim_t s;
    exp_t  o, e;
    cur_test = "down_wrap";
    sq.push_back(mk_s(1, 0, 0, 0, 0, 0)); q.push_back(mk_e(0, 1, 0, 0));
    for (int i = 0; i < 3; i++) begin sq.push_back(mk_s(0, 0, 0, 0, 0, 0)); q.push_back(mk_e(0, 1, 0, 0)); end
    sq.push_back(mk_s(0, 0, 0, 0, 0, 0)); q.push_back(mk_e(10, 1, 1, 0));
    for (int i = 0; i < 3; i++) begin sq.push_back(mk_s(0, 0, 0, 0, 0, 0)); q.push_back(mk_e(10, 1, 0, 0)); end
    sq.push_back(mk_s(0, 0, 0, 0, 0, 0)); q.push_back(mk_e(9, 1, 0, 0));
    for (int i = 0; i < 2; i++) begin sq.push_back(mk_s(0, 0, 0, 0, 0, 0)); q.push_back(mk_e(9, 1, 0, 0)); end
    // direction flips mid-prescale; only the next step sees it
    sq.push_back(mk_s(0, 0, 1, 0, 0, 0)); q.push_back(mk_e(9, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 1, 0, 0, 0)); q.push_back(mk_e(10, 1, 0, 0));
    for (int r = 0; sq.size() > 0; r++) begin
      s = sq.pop_front();
      drive4(s);
      @(posedge clk);
      @(negedge clk);
      o = obs4();
      e = q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s row=%0d got cnt=%0d run=%0b tc=%0b err=%0b exp cnt=%0d run=%0b tc=%0b err=%0b",
                 cur_test, r, o.count, o.running, o.tc, o.load_err, e.count, e.running, e.tc, e.load_err);
      end
    end
  endtask

  task automatic test_load();
    stim_t sq[$];
    stim_t s;
    exp_t  o, e;
    cur_test = "load";
    sq.push_back(mk_s(0, 0, 1, 0, 1, 7)); q.push_back(mk_e(7, 1, 0, 0));
    for (int i = 0; i < 3; i++) begin sq.push_back(mk_s(0, 0, 1, 0, 0, 0)); q.push_back(mk_e(7, 1, 0, 0)); end
    sq.push_back(mk_s(0, 0, 1, 0, 0, 0));  q.push_back(mk_e(8, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 1, 0, 1, 10)); q.push_back(mk_e(10, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 1, 0, 1, 13)); q.push_back(mk_e(10, 1, 0, 1));
    sq.push_back(mk_s(0, 0, 1, 0, 0, 0));  q.push_back(mk_e(10, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 1, 1, 1, 13)); q.push_back(mk_e(0, 1, 0, 0));
    for (int i = 0; i < 3; i++) begin sq.push_back(mk_s(0, 0, 1, 0, 0, 0)); q.push_back(mk_e(0, 1, 0, 0)); end
    sq.push_back(mk_s(0, 0, 1, 0, 0, 0));  q.push_back(mk_e(1, 1, 0, 0));
    for (int r = 0; sq.size() > 0; r++) begin
      s = sq.pop_front();
      drive4(s);
      @(posedge clk);
      @(negedge clk);
      o = obs4();
      e = q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s row=%0d got cnt=%0d run=%0b tc=%0b err=%0b exp cnt=%0d run=%0b tc=%0b err=%0b",
                 cur_test, r, o.count, o.running, o.tc, o.load_err, e.count, e.running, e.tc, e.load_err);
      end
    end
  endtask

  task automatic test_collisions();
    stim_t sq[$];
    stim_t s;
    exp_t  o, e;
    cur_test = "collisions";
    for (int i = 0; i < 3; i++) begin sq.push_back(mk_s(0, 0, 1, 0, 0, 0)); q.push_back(mk_e(1, 1, 0, 0)); end
    sq.push_back(mk_s(0, 1, 1, 0, 0, 0)); q.push_back(mk_e(1, 0, 0, 0));
    sq.push_back(mk_s(1, 1, 1, 0, 0, 0)); q.push_back(mk_e(1, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 1, 0, 0, 0)); q.push_back(mk_e(1, 0, 0, 0));
    sq.push_back(mk_s(1, 0, 1, 0, 0, 0)); q.push_back(mk_e(1, 1, 0, 0));
    sq.push_back(mk_s(1, 0, 1, 0, 0, 0)); q.push_back(mk_e(1, 1, 0, 0));
    sq.push_back(mk_s(1, 0, 1, 0, 0, 0)); q.push_back(mk_e(1, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 1, 0, 0, 0)); q.push_back(mk_e(1, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 1, 0, 0, 0)); q.push_back(mk_e(2, 1, 0, 0));
    sq.push_back(mk_s(0, 1, 1, 0, 0, 0)); q.push_back(mk_e(2, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 1, 0, 1, 5)); q.push_back(mk_e(5, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 1, 1, 0, 0)); q.push_back(mk_e(0, 0, 0, 0));
    for (int r = 0; sq.size() > 0; r++) begin
      s = sq.pop_front();
      drive4(s);
      @(posedge clk);
      @(negedge clk);
      o = obs4();
      e = q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s row=%0d got cnt=%0d run=%0b tc=%0b err=%0b exp cnt=%0d run=%0b tc=%0b err=%0b",
                 cur_test, r, o.count, o.running, o.tc, o.load_err, e.count, e.running, e.tc, e.load_err);
      end
    end
    drive4('0);
  endtask

  task automatic test_async_reset();
    stim_t sq[$];
    stim_t s;
    exp_t  o, e;
    cur_test = "async_reset";
    sq.push_back(mk_s(0, 0, 1, 1, 0, 0)); q.push_back(mk_e(0, 0, 0, 0));
    sq.push_back(mk_s(1, 0, 1, 0, 0, 0)); q.push_back(mk_e(0, 1, 0, 0));
    for (int i = 1; i <= 6; i++) begin sq.push_back(mk_s(0, 0, 1, 0, 0, 0)); q.push_back(mk_e(i, 1, 0, 0)); end
    for (int r = 0; sq.size() > 0; r++) begin
      s = sq.pop_front();
      drive1(s);
      @(posedge clk);
      @(negedge clk);
      o = obs1();
      e = q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s row=%0d got cnt=%0d run=%0b tc=%0b err=%0b exp cnt=%0d run=%0b tc=%0b err=%0b",
                 cur_test, r, o.count, o.running, o.tc, o.load_err, e.count, e.running, e.tc, e.load_err);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    o = obs1();
    checks++;
    if (o !== exp_t'('0)) begin
      failures++;
      $display("FAIL async_reset_immediate got=%h exp=%h", o, exp_t'('0));
    end
    drive1(mk_s(0, 0, 1, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      q.push_back(mk_e(0, 0, 0, 0));
      @(posedge clk);
      @(negedge clk);
      o = obs1();
      e = q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL async_reset_idle row=%0d got cnt=%0d run=%0b tc=%0b err=%0b exp cnt=%0d run=%0b tc=%0b err=%0b",
                 r, o.count, o.running, o.tc, o.load_err, e.count, e.running, e.tc, e.load_err);
      end
    end
    drive1('0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive1('0);
    drive4('0);
    @(negedge clk);
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_collisions();
    test_async_reset();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
